map_server: RTL and testbench

- Responder side of the display's map-request interface. Holds the game-field wall bitmap.
- Answers the display's per-cell (request_x, request_y) lookups with is_wall one cycle later.
- Serves a second registered query port for game logic.
- Applies queued wall edits from game logic (e.g. shell hits) only while the display is not scanning visible lines, so a frame never shows a half-applied edit.
- Sits between the game controller and the VGA block.

---
 rtl/map_pkg.sv | 54 +++++
 rtl/map_wr_fifo.sv | 64 ++++++
 rtl/map_server.sv | 133 +++++++++++++
 tb/tb_map_server.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// map_pkg
// Shared types, dimensions and helper functions for the map server.
//   MAP_W / MAP_H     : grid size (64 columns, 44 game rows)
//   map_state_t       : map server FSM states
//   map_wr_t          : one queued wall edit {x, y, wall}
//   is_border()       : true for the indestructible outer ring
//   init_row()        : power-on wall pattern for one row
package map_pkg;

  localparam int MAP_W = 64;
  localparam int MAP_H = 44;

  // 6-bit coordinate forms of the limits, so comparisons against the
  // 6-bit request/query/write coordinates stay width-matched.
  localparam logic [5:0] X_LAST  = 6'(MAP_W - 1);
  localparam logic [5:0] Y_LAST  = 6'(MAP_H - 1);
  localparam logic [5:0] Y_LIMIT = 6'(MAP_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    READY = 2'd2
  } map_state_t;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic       wall;
  } map_wr_t;

  function automatic logic is_border(input logic [5:0] x, input logic [5:0] y);
    return (x == 6'd0) || (x == X_LAST) || (y == 6'd0) || (y == Y_LAST);
  endfunction

  // Outer ring plus three vertical interior walls at x = 16/32/48
  // spanning rows 10..33.
  function automatic logic [MAP_W-1:0] init_row(input logic [5:0] y);
    logic [MAP_W-1:0] r;
    r = '0;
    if ((y == 6'd0) || (y == Y_LAST)) begin
      r = '1;
    end else begin
      r[0]       = 1'b1;
      r[MAP_W-1] = 1'b1;
      if ((y >= 6'd10) && (y <= 6'd33)) begin
        r[16] = 1'b1;
        r[32] = 1'b1;
        r[48] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/map_wr_fifo.sv
// map_wr_fifo
// Small synchronous FIFO holding pending wall edits until the display
// leaves the visible area.
//   clk, rst_n : clock, async active-low reset
//   i_push     : write i_data (caller guarantees !o_full)
//   i_pop      : drop head entry (caller guarantees !o_empty)
//   i_flush    : discard all entries; wins over push/pop
//   o_data     : head entry
//   o_full     : DEPTH entries stored
//   o_empty    : no entries stored
module map_wr_fifo
  import map_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_push,
  input  map_wr_t i_data,
  input  logic    i_pop,
  input  logic    i_flush,
  output map_wr_t o_data,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  map_wr_t        mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;

  // Storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (i_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (i_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({i_push, i_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);

endmodule

// File: rtl/map_server.sv
// map_server
// Holds the game-field wall bitmap, answers display and game-logic
// lookups with one cycle of latency, and applies queued wall edits only
// while the display is outside the visible lines.
//   clk, rst_n               : clock, async active-low reset
//   i_state                  : game state, 2'b01 = game running
//   i_vga_buzy               : display scanning visible lines
//   i_request_x/y, o_is_wall : display lookup port
//   i_query_x/y, o_query_wall: game-logic lookup port
//   i_wr_valid/o_wr_ready, i_wr_x/y/wall : wall edit command port
//   o_init_done              : map loaded and server in READY
module map_server
  import map_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_state,
  input  logic       i_vga_buzy,
  input  logic [5:0] i_request_x,
  input  logic [5:0] i_request_y,
  output logic       o_is_wall,
  input  logic [5:0] i_query_x,
  input  logic [5:0] i_query_y,
  output logic       o_query_wall,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [5:0] i_wr_x,
  input  logic [5:0] i_wr_y,
  input  logic       i_wr_wall,
  output logic       o_init_done
);

  map_state_t       state_q, state_d;
  logic [5:0]       row_q, row_d;
  logic [MAP_W-1:0] map_q [MAP_H];
  logic             is_wall_q, query_wall_q;

  logic    game_on;
  logic    fifo_full, fifo_empty;
  logic    push, pop;
  map_wr_t wr_in, wr_head;
  logic    init_wr, commit_wr;

  assign game_on = (i_state == 2'b01);

  assign wr_in = '{x: i_wr_x, y: i_wr_y, wall: i_wr_wall};

  assign o_wr_ready = (state_q == READY) && !fifo_full;
  assign push       = i_wr_valid && o_wr_ready;
  assign pop        = (state_q == READY) && !i_vga_buzy && !fifo_empty;

  // A popped entry only touches the map if it lands inside the grid and
  // off the border ring; otherwise it is silently consumed. x can never
  // exceed the 64-column width, so only y needs a range check.
  assign init_wr   = (state_q == INIT) && game_on;
  assign commit_wr = pop && (wr_head.y < Y_LIMIT) && !is_border(wr_head.x, wr_head.y);

  map_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (push),
    .i_data (wr_in),
    .i_pop  (pop),
    .i_flush(!game_on),
    .o_data (wr_head),
    .o_full (fifo_full),
    .o_empty(fifo_empty)
  );

  // Leaving the game state from anywhere forces IDLE, so re-entry always
  // reloads the full map pattern.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        row_d = '0;
        if (game_on) state_d = INIT;
      end
      INIT: begin
        row_d = row_q + 6'd1;
        if (row_q == Y_LAST) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = IDLE;
    endcase
    if (!game_on) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // INIT and commit are mutually exclusive by state, so a row sees at
  // most one writer per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MAP_H; r++) map_q[r] <= '0;
    end else begin
      for (int r = 0; r < MAP_H; r++) begin
        if (init_wr && (row_q == 6'(r))) map_q[r] <= init_row(6'(r));
        if (commit_wr && (wr_head.y == 6'(r))) map_q[r][wr_head.x] <= wr_head.wall;
      end
    end
  end

  // Both lookup ports read committed contents and answer next cycle;
  // rows beyond the game grid (status area) read as open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_wall_q    <= 1'b0;
      query_wall_q <= 1'b0;
    end else begin
      is_wall_q    <= (i_request_y < Y_LIMIT) ? map_q[i_request_y][i_request_x] : 1'b0;
      query_wall_q <= (i_query_y < Y_LIMIT) ? map_q[i_query_y][i_query_x] : 1'b0;
    end
  end

  assign o_is_wall    = is_wall_q;
  assign o_query_wall = query_wall_q;
  assign o_init_done  = (state_q == READY);

endmodule

// File: tb/tb_map_server.sv
// tb_map_server
// Directed bench for map_server: init timing and pattern, both lookup
// ports, buffered edits held off by i_vga_buzy, dropped border and
// out-of-range edits, abort/re-init, and asynchronous reset.
module tb_map_server;

  logic       clk;
  logic       rst_n;
  logic [1:0] i_state;
  logic       i_vga_buzy;
  logic [5:0] i_request_x, i_request_y;
  logic       o_is_wall;
  logic [5:0] i_query_x, i_query_y;
  logic       o_query_wall;
  logic       i_wr_valid;
  logic       o_wr_ready;
  logic [5:0] i_wr_x, i_wr_y;
  logic       i_wr_wall;
  logic       o_init_done;

  int checks = 0;
  int errors = 0;

  map_server #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_state     (i_state),
    .i_vga_buzy  (i_vga_buzy),
    .i_request_x (i_request_x),
    .i_request_y (i_request_y),
    .o_is_wall   (o_is_wall),
    .i_query_x   (i_query_x),
    .i_query_y   (i_query_y),
    .o_query_wall(o_query_wall),
    .i_wr_valid  (i_wr_valid),
    .o_wr_ready  (o_wr_ready),
    .i_wr_x      (i_wr_x),
    .i_wr_y      (i_wr_y),
    .i_wr_wall   (i_wr_wall),
    .o_init_done (o_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a display request, step one clock, compare o_is_wall.
  task automatic applyStimulus(input logic [5:0] x, input logic [5:0] y, input logic exp, input string tag);
    i_request_x = x;
    i_request_y = y;
    tick();
    checkOutput(tag, 32'(o_is_wall), 32'(exp));
  endtask

  task automatic queryCell(input logic [5:0] x, input logic [5:0] y, input logic exp, input string tag);
    i_query_x = x;
    i_query_y = y;
    tick();
    checkOutput(tag, 32'(o_query_wall), 32'(exp));
  endtask

  // One-cycle write command; caller has arranged for o_wr_ready.
  task automatic pushWrite(input logic [5:0] x, input logic [5:0] y, input logic w);
    i_wr_valid = 1'b1;
    i_wr_x     = x;
    i_wr_y     = y;
    i_wr_wall  = w;
    tick();
    i_wr_valid = 1'b0;
  endtask

  initial begin
    logic seen;
    rst_n       = 1'b0;
    i_state     = 2'b00;
    i_vga_buzy  = 1'b0;
    i_request_x = '0;
    i_request_y = '0;
    i_query_x   = '0;
    i_query_y   = '0;
    i_wr_valid  = 1'b0;
    i_wr_x      = '0;
    i_wr_y      = '0;
    i_wr_wall   = 1'b0;

    // Reset values and init timing
    ticks(2);
    checkOutput("rst_init_done", 32'(o_init_done), 32'd0);
    checkOutput("rst_wr_ready", 32'(o_wr_ready), 32'd0);
    checkOutput("rst_is_wall", 32'(o_is_wall), 32'd0);
    i_state = 2'b01;
    rst_n   = 1'b1;
    ticks(44);
    checkOutput("init_not_yet", 32'(o_init_done), 32'd0);
    checkOutput("init_ready_low", 32'(o_wr_ready), 32'd0);
    tick();
    checkOutput("init_done", 32'(o_init_done), 32'd1);
    checkOutput("ready_after_init", 32'(o_wr_ready), 32'd1);

    applyStimulus(6'd0,  6'd5,  1'b1, "disp_0_5");
    applyStimulus(6'd5,  6'd5,  1'b0, "disp_5_5");
    applyStimulus(6'd16, 6'd20, 1'b1, "disp_16_20");
    applyStimulus(6'd16, 6'd5,  1'b0, "disp_16_5");
    applyStimulus(6'd63, 6'd43, 1'b1, "disp_63_43");
    applyStimulus(6'd48, 6'd33, 1'b1, "disp_48_33");
    applyStimulus(6'd48, 6'd34, 1'b0, "disp_48_34");
    queryCell(6'd32, 6'd10, 1'b1, "query_32_10");

    // Edit held while the display is busy
    i_vga_buzy = 1'b1;
    pushWrite(6'd5, 6'd5, 1'b1);
    i_query_x = 6'd5;
    i_query_y = 6'd5;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (o_query_wall) seen = 1'b1;
    end
    checkOutput("buzy_hold", 32'(seen), 32'd0);
    i_vga_buzy = 1'b0;
    tick();
    checkOutput("commit_same_cycle_old", 32'(o_query_wall), 32'd0);
    tick();
    checkOutput("commit_next_new", 32'(o_query_wall), 32'd1);

    // Fill the queue, then drain in order
    i_vga_buzy = 1'b1;
    pushWrite(6'd7, 6'd7, 1'b1);
    pushWrite(6'd8, 6'd8, 1'b1);
    pushWrite(6'd7, 6'd7, 1'b0);
    checkOutput("ready_before_4th", 32'(o_wr_ready), 32'd1);
    pushWrite(6'd9, 6'd9, 1'b1);
    checkOutput("full_ready_low", 32'(o_wr_ready), 32'd0);
    i_vga_buzy = 1'b0;
    tick();
    checkOutput("ready_after_pop", 32'(o_wr_ready), 32'd1);
    ticks(3);
    queryCell(6'd7, 6'd7, 1'b0, "last_write_wins");
    queryCell(6'd8, 6'd8, 1'b1, "cell_8_8");
    queryCell(6'd9, 6'd9, 1'b1, "cell_9_9");

    // Border and out-of-range edits are consumed without effect
    pushWrite(6'd0,  6'd10, 1'b0);
    pushWrite(6'd20, 6'd50, 1'b1);
    pushWrite(6'd30, 6'd43, 1'b0);
    ticks(2);
    checkOutput("drop_ready", 32'(o_wr_ready), 32'd1);
    queryCell(6'd0,  6'd10, 1'b1, "border_left_kept");
    queryCell(6'd30, 6'd43, 1'b1, "border_bottom_kept");
    queryCell(6'd20, 6'd50, 1'b0, "query_status_row");
    applyStimulus(6'd0, 6'd45, 1'b0, "disp_y45");

    // Clear interior walls, leave one edit pending, then abort
    pushWrite(6'd16, 6'd20, 1'b0);
    pushWrite(6'd32, 6'd30, 1'b0);
    ticks(2);
    queryCell(6'd16, 6'd20, 1'b0, "cleared_16_20");
    queryCell(6'd32, 6'd30, 1'b0, "cleared_32_30");
    i_vga_buzy = 1'b1;
    pushWrite(6'd40, 6'd5, 1'b1);
    i_state = 2'b00;
    tick();
    checkOutput("leave_idle_done", 32'(o_init_done), 32'd0);
    checkOutput("leave_idle_ready", 32'(o_wr_ready), 32'd0);
    i_vga_buzy = 1'b0;

    // Re-enter, abort at INIT row 20 (rows 0..19 reloaded only)
    i_state = 2'b01;
    ticks(21);
    i_state = 2'b00;
    tick();
    checkOutput("abort_done", 32'(o_init_done), 32'd0);
    checkOutput("abort_ready", 32'(o_wr_ready), 32'd0);
    queryCell(6'd32, 6'd30, 1'b0, "stale_32_30");
    queryCell(6'd16, 6'd20, 1'b0, "stale_16_20");

    // Full re-init restores the pattern; flushed edit never lands
    i_state = 2'b01;
    ticks(44);
    checkOutput("reinit_not_yet", 32'(o_init_done), 32'd0);
    tick();
    checkOutput("reinit_done", 32'(o_init_done), 32'd1);
    queryCell(6'd16, 6'd20, 1'b1, "restored_16_20");
    queryCell(6'd32, 6'd30, 1'b1, "restored_32_30");
    queryCell(6'd40, 6'd5,  1'b0, "flushed_40_5");
    queryCell(6'd5,  6'd5,  1'b0, "restored_5_5");

    // Asynchronous reset between edges
    i_request_x = 6'd0;
    i_request_y = 6'd5;
    i_query_x   = 6'd0;
    i_query_y   = 6'd5;
    tick();
    checkOutput("pre_rst_is_wall", 32'(o_is_wall), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_is_wall", 32'(o_is_wall), 32'd0);
    checkOutput("async_query", 32'(o_query_wall), 32'd0);
    checkOutput("async_ready", 32'(o_wr_ready), 32'd0);
    checkOutput("async_done", 32'(o_init_done), 32'd0);
    i_state = 2'b00;
    ticks(2);
    rst_n = 1'b1;
    ticks(2);
    checkOutput("post_rst_done", 32'(o_init_done), 32'd0);
    queryCell(6'd0, 6'd5, 1'b0, "post_rst_map_clear");
    i_state = 2'b01;
    ticks(44);
    checkOutput("post_rst_init_wait", 32'(o_init_done), 32'd0);
    tick();
    checkOutput("post_rst_init_done", 32'(o_init_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
